// File: rtl/multicycle_control_fsm_pkg.sv
// Shared encodings for the multi-cycle MIPS control path: opcodes, datapath
// select codes, ALUOp values seen by the ALU control unit, and FSM states.
package mips_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_SLTIU = 6'b001011;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_LBU   = 6'b100100;
    localparam logic [5:0] OP_LHU   = 6'b100101;
    localparam logic [5:0] OP_SB    = 6'b101000;
    localparam logic [5:0] OP_SH    = 6'b101001;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [2:0] ALUOP_ADD   = 3'b000;
    localparam logic [2:0] ALUOP_SUB   = 3'b001;
    localparam logic [2:0] ALUOP_RTYPE = 3'b010;
    localparam logic [2:0] ALUOP_AND   = 3'b100;
    localparam logic [2:0] ALUOP_OR    = 3'b101;
    localparam logic [2:0] ALUOP_SLT   = 3'b110;

    localparam logic [1:0] SRCA_PC   = 2'b00;
    localparam logic [1:0] SRCA_REG  = 2'b01;
    localparam logic [1:0] SRCA_ZERO = 2'b10;

    localparam logic [2:0] SRCB_REG     = 3'b000;
    localparam logic [2:0] SRCB_FOUR    = 3'b001;
    localparam logic [2:0] SRCB_IMM     = 3'b010;
    localparam logic [2:0] SRCB_IMM_SH2 = 3'b011;
    localparam logic [2:0] SRCB_ZIMM    = 3'b100;
    localparam logic [2:0] SRCB_LUI     = 3'b101;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    localparam logic [1:0] MSZ_WORD = 2'b00;
    localparam logic [1:0] MSZ_HALF = 2'b01;
    localparam logic [1:0] MSZ_BYTE = 2'b10;

    typedef enum logic [2:0] {
        CLS_R       = 3'd0,
        CLS_JUMP    = 3'd1,
        CLS_BRANCH  = 3'd2,
        CLS_LOAD    = 3'd3,
        CLS_STORE   = 3'd4,
        CLS_IMM     = 3'd5,
        CLS_ILLEGAL = 3'd6
    } op_class_e;

    typedef enum logic [3:0] {
        ST_FETCH     = 4'd0,
        ST_DECODE    = 4'd1,
        ST_MEM_ADDR  = 4'd2,
        ST_MEM_READ  = 4'd3,
        ST_MEM_WB    = 4'd4,
        ST_MEM_WRITE = 4'd5,
        ST_R_EXEC    = 4'd6,
        ST_R_WB      = 4'd7,
        ST_BRANCH    = 4'd8,
        ST_JUMP      = 4'd9,
        ST_I_EXEC    = 4'd10,
        ST_I_WB      = 4'd11,
        ST_ILLEGAL   = 4'd12
    } state_e;

endpackage

// File: rtl/multicycle_control_fsm_if.sv
// Control bundle between the main FSM (master) and the datapath (slave).
interface multicycle_control_fsm_if #(
    parameter int CNT_W = 32
);
    logic [5:0]       opcode;
    logic             mem_ready;
    logic             PCWrite;
    logic             PCWriteCondEq;
    logic             PCWriteCondNe;
    logic             IorD;
    logic             MemRead;
    logic             MemWrite;
    logic [1:0]       MemSize;
    logic             IRWrite;
    logic             MemtoReg;
    logic             RegDst;
    logic             RegWrite;
    logic [1:0]       PCSource;
    logic [1:0]       ALUSrcA;
    logic [2:0]       ALUSrcB;
    logic [2:0]       ALUOp;
    logic             illegal_op;
    logic             retired;
    logic [CNT_W-1:0] instr_count;

    modport master (
        input  opcode, mem_ready,
        output PCWrite, PCWriteCondEq, PCWriteCondNe, IorD, MemRead, MemWrite,
               MemSize, IRWrite, MemtoReg, RegDst, RegWrite, PCSource,
               ALUSrcA, ALUSrcB, ALUOp, illegal_op, retired, instr_count
    );

    modport slave (
        output opcode, mem_ready,
        input  PCWrite, PCWriteCondEq, PCWriteCondNe, IorD, MemRead, MemWrite,
               MemSize, IRWrite, MemtoReg, RegDst, RegWrite, PCSource,
               ALUSrcA, ALUSrcB, ALUOp, illegal_op, retired, instr_count
    );
endinterface

// File: rtl/multicycle_control_fsm_decoder.sv
// Combinational opcode classifier: instruction class, access size and the
// I-type ALU setup, so the FSM only has to sequence states.
module mc_opcode_decoder
    import mips_ctrl_pkg::*;
(
    input  logic [5:0] opcode,
    output op_class_e  op_class,
    output logic       is_bne,
    output logic [1:0] mem_size,
    output logic [2:0] imm_alu_op,
    output logic [1:0] imm_src_a,
    output logic [2:0] imm_src_b
);

    // Opcode classification and per-opcode datapath setup
    always_comb begin
        op_class   = CLS_ILLEGAL;
        is_bne     = 1'b0;
        mem_size   = MSZ_WORD;
        imm_alu_op = ALUOP_ADD;
        imm_src_a  = SRCA_REG;
        imm_src_b  = SRCB_IMM;
        case (opcode)
            OP_RTYPE: op_class = CLS_R;
            OP_J:     op_class = CLS_JUMP;
            OP_BEQ:   op_class = CLS_BRANCH;
            OP_BNE: begin
                op_class = CLS_BRANCH;
                is_bne   = 1'b1;
            end
            OP_LW:    op_class = CLS_LOAD;
            OP_LHU: begin
                op_class = CLS_LOAD;
                mem_size = MSZ_HALF;
            end
            OP_LBU: begin
                op_class = CLS_LOAD;
                mem_size = MSZ_BYTE;
            end
            OP_SW:    op_class = CLS_STORE;
            OP_SH: begin
                op_class = CLS_STORE;
                mem_size = MSZ_HALF;
            end
            OP_SB: begin
                op_class = CLS_STORE;
                mem_size = MSZ_BYTE;
            end
            OP_ADDI, OP_ADDIU: op_class = CLS_IMM;
            OP_SLTI, OP_SLTIU: begin
                op_class   = CLS_IMM;
                imm_alu_op = ALUOP_SLT;
            end
            OP_ANDI: begin
                op_class   = CLS_IMM;
                imm_alu_op = ALUOP_AND;
                imm_src_b  = SRCB_ZIMM;
            end
            OP_ORI: begin
                op_class   = CLS_IMM;
                imm_alu_op = ALUOP_OR;
                imm_src_b  = SRCB_ZIMM;
            end
            OP_LUI: begin
                op_class  = CLS_IMM;
                imm_src_a = SRCA_ZERO;
                imm_src_b = SRCB_LUI;
            end
            default: op_class = CLS_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Main control FSM of the multi-cycle MIPS datapath: Moore output decode per
// state, memory-ready stalls, and a retired-instruction counter.
module multicycle_control_fsm
    import mips_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    multicycle_control_fsm_if.master bus
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_e           state_q, state_d;
    logic [CNT_W-1:0] instr_count_q, instr_count_d;

    op_class_e  op_class_s;
    logic       is_bne_s;
    logic [1:0] mem_size_s;
    logic [2:0] imm_alu_op_s;
    logic [1:0] imm_src_a_s;
    logic [2:0] imm_src_b_s;

    logic       pc_write_s, cond_eq_s, cond_ne_s, iord_s, mem_read_s, mem_write_s;
    logic [1:0] mem_size_out_s;
    logic       ir_write_s, memtoreg_s, regdst_s, reg_write_s;
    logic [1:0] pc_source_s, alu_src_a_s;
    logic [2:0] alu_src_b_s, alu_op_s;
    logic       illegal_s, retired_s;

    mc_opcode_decoder u_dec (
        .opcode     (bus.opcode),
        .op_class   (op_class_s),
        .is_bne     (is_bne_s),
        .mem_size   (mem_size_s),
        .imm_alu_op (imm_alu_op_s),
        .imm_src_a  (imm_src_a_s),
        .imm_src_b  (imm_src_b_s)
    );

    // Next-state and output decode; reset forces every output low
    always_comb begin
        state_d        = state_q;
        pc_write_s     = 1'b0;
        cond_eq_s      = 1'b0;
        cond_ne_s      = 1'b0;
        iord_s         = 1'b0;
        mem_read_s     = 1'b0;
        mem_write_s    = 1'b0;
        mem_size_out_s = MSZ_WORD;
        ir_write_s     = 1'b0;
        memtoreg_s     = 1'b0;
        regdst_s       = 1'b0;
        reg_write_s    = 1'b0;
        pc_source_s    = PCSRC_ALU;
        alu_src_a_s    = SRCA_PC;
        alu_src_b_s    = SRCB_REG;
        alu_op_s       = ALUOP_ADD;
        illegal_s      = 1'b0;
        retired_s      = 1'b0;
        if (rst) begin
            state_d = ST_FETCH;
        end else begin
            case (state_q)
                ST_FETCH: begin
                    mem_read_s  = 1'b1;
                    alu_src_b_s = SRCB_FOUR;
                    ir_write_s  = bus.mem_ready;
                    pc_write_s  = bus.mem_ready;
                    state_d     = bus.mem_ready ? ST_DECODE : ST_FETCH;
                end
                ST_DECODE: begin
                    alu_src_b_s = SRCB_IMM_SH2;
                    case (op_class_s)
                        CLS_R:              state_d = ST_R_EXEC;
                        CLS_JUMP:           state_d = ST_JUMP;
                        CLS_BRANCH:         state_d = ST_BRANCH;
                        CLS_LOAD, CLS_STORE: state_d = ST_MEM_ADDR;
                        CLS_IMM:            state_d = ST_I_EXEC;
                        default:            state_d = ST_ILLEGAL;
                    endcase
                end
                ST_MEM_ADDR: begin
                    alu_src_a_s = SRCA_REG;
                    alu_src_b_s = SRCB_IMM;
                    state_d     = (op_class_s == CLS_LOAD) ? ST_MEM_READ : ST_MEM_WRITE;
                end
                ST_MEM_READ: begin
                    iord_s         = 1'b1;
                    mem_read_s     = 1'b1;
                    mem_size_out_s = mem_size_s;
                    state_d        = bus.mem_ready ? ST_MEM_WB : ST_MEM_READ;
                end
                ST_MEM_WB: begin
                    memtoreg_s  = 1'b1;
                    reg_write_s = 1'b1;
                    retired_s   = 1'b1;
                    state_d     = ST_FETCH;
                end
                ST_MEM_WRITE: begin
                    iord_s         = 1'b1;
                    mem_write_s    = 1'b1;
                    mem_size_out_s = mem_size_s;
                    retired_s      = bus.mem_ready;
                    state_d        = bus.mem_ready ? ST_FETCH : ST_MEM_WRITE;
                end
                ST_R_EXEC: begin
                    alu_src_a_s = SRCA_REG;
                    alu_op_s    = ALUOP_RTYPE;
                    state_d     = ST_R_WB;
                end
                ST_R_WB: begin
                    regdst_s    = 1'b1;
                    reg_write_s = 1'b1;
                    retired_s   = 1'b1;
                    state_d     = ST_FETCH;
                end
                ST_BRANCH: begin
                    alu_src_a_s = SRCA_REG;
                    alu_op_s    = ALUOP_SUB;
                    pc_source_s = PCSRC_ALUOUT;
                    cond_eq_s   = ~is_bne_s;
                    cond_ne_s   = is_bne_s;
                    retired_s   = 1'b1;
                    state_d     = ST_FETCH;
                end
                ST_JUMP: begin
                    pc_source_s = PCSRC_JUMP;
                    pc_write_s  = 1'b1;
                    retired_s   = 1'b1;
                    state_d     = ST_FETCH;
                end
                ST_I_EXEC: begin
                    alu_src_a_s = imm_src_a_s;
                    alu_src_b_s = imm_src_b_s;
                    alu_op_s    = imm_alu_op_s;
                    state_d     = ST_I_WB;
                end
                ST_I_WB: begin
                    reg_write_s = 1'b1;
                    retired_s   = 1'b1;
                    state_d     = ST_FETCH;
                end
                ST_ILLEGAL: begin
                    illegal_s = 1'b1;
                    state_d   = ST_FETCH;
                end
                default: state_d = ST_FETCH;
            endcase
        end
    end

    // Retired-instruction counter, wraps modulo 2^CNT_W
    always_comb begin
        if (retired_s) begin
            instr_count_d = instr_count_q + CNT_ONE;
        end else begin
            instr_count_d = instr_count_q;
        end
    end

    // State and counter registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_FETCH;
            instr_count_q <= {CNT_W{1'b0}};
        end else begin
            state_q       <= state_d;
            instr_count_q <= instr_count_d;
        end
    end

    assign bus.PCWrite       = pc_write_s;
    assign bus.PCWriteCondEq = cond_eq_s;
    assign bus.PCWriteCondNe = cond_ne_s;
    assign bus.IorD          = iord_s;
    assign bus.MemRead       = mem_read_s;
    assign bus.MemWrite      = mem_write_s;
    assign bus.MemSize       = mem_size_out_s;
    assign bus.IRWrite       = ir_write_s;
    assign bus.MemtoReg      = memtoreg_s;
    assign bus.RegDst        = regdst_s;
    assign bus.RegWrite      = reg_write_s;
    assign bus.PCSource      = pc_source_s;
    assign bus.ALUSrcA       = alu_src_a_s;
    assign bus.ALUSrcB       = alu_src_b_s;
    assign bus.ALUOp         = alu_op_s;
    assign bus.illegal_op    = illegal_s;
    assign bus.retired       = retired_s;
    assign bus.instr_count   = instr_count_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for multicycle_control_fsm: walks instruction classes cycle
// by cycle and compares the full control word against hand-written values.
module tb_multicycle_control_fsm;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    multicycle_control_fsm_if #(.CNT_W(32)) bus ();

    multicycle_control_fsm #(.CNT_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    logic [23:0] act_vec;
    assign act_vec = {bus.PCWrite, bus.PCWriteCondEq, bus.PCWriteCondNe, bus.IorD,
                      bus.MemRead, bus.MemWrite, bus.MemSize, bus.IRWrite,
                      bus.MemtoReg, bus.RegDst, bus.RegWrite, bus.PCSource,
                      bus.ALUSrcA, bus.ALUSrcB, bus.ALUOp, bus.illegal_op, bus.retired};

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Pack a control word in the same field order as act_vec.
    function automatic logic [23:0] mk(
        input logic pcw, ceq, cne, iord, mrd, mwr,
        input logic [1:0] msz,
        input logic irw, m2r, rdst, rw,
        input logic [1:0] pcs, sa,
        input logic [2:0] sb, aop,
        input logic ill, ret);
        return {pcw, ceq, cne, iord, mrd, mwr, msz, irw, m2r, rdst, rw, pcs, sa, sb, aop, ill, ret};
    endfunction

    function automatic logic [23:0] v_fetch(input logic mr);
        return mk(mr, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, mr, 1'b0, 1'b0, 1'b0,
                  2'b00, 2'b00, 3'b001, 3'b000, 1'b0, 1'b0);
    endfunction
    function automatic logic [23:0] v_decode();
        return mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0,
                  2'b00, 2'b00, 3'b011, 3'b000, 1'b0, 1'b0);
    endfunction
    function automatic logic [23:0] v_alu(input logic [1:0] sa, input logic [2:0] sb, input logic [2:0] aop);
        return mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0,
                  2'b00, sa, sb, aop, 1'b0, 1'b0);
    endfunction
    function automatic logic [23:0] v_wb(input logic m2r, input logic rdst);
        return mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, m2r, rdst, 1'b1,
                  2'b00, 2'b00, 3'b000, 3'b000, 1'b0, 1'b1);
    endfunction
    function automatic logic [23:0] v_memrd(input logic [1:0] msz);
        return mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, msz, 1'b0, 1'b0, 1'b0, 1'b0,
                  2'b00, 2'b00, 3'b000, 3'b000, 1'b0, 1'b0);
    endfunction
    function automatic logic [23:0] v_memwr(input logic [1:0] msz, input logic ret);
        return mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, msz, 1'b0, 1'b0, 1'b0, 1'b0,
                  2'b00, 2'b00, 3'b000, 3'b000, 1'b0, ret);
    endfunction
    function automatic logic [23:0] v_branch(input logic ne);
        return mk(1'b0, ~ne, ne, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0,
                  2'b01, 2'b01, 3'b000, 3'b001, 1'b0, 1'b1);
    endfunction

    // One clock of stimulus: drive on the falling edge, sample 1 ns later.
    task automatic step(input logic r, input logic [5:0] op, input logic mr,
                        input string tag, input logic [23:0] exp);
        @(negedge clk);
        rst = r;
        bus.opcode = op;
        bus.mem_ready = mr;
        #1;
        check_eq(tag, {40'd0, act_vec}, {40'd0, exp});
    endtask

    task automatic run_imm(input logic [5:0] op, input string tag,
                           input logic [1:0] sa, input logic [2:0] sb, input logic [2:0] aop);
        step(1'b0, op, 1'b1, {tag, "_fetch"}, v_fetch(1'b1));
        step(1'b0, op, 1'b1, {tag, "_decode"}, v_decode());
        step(1'b0, op, 1'b1, {tag, "_exec"}, v_alu(sa, sb, aop));
        step(1'b0, op, 1'b1, {tag, "_wb"}, v_wb(1'b0, 1'b0));
    endtask

    initial begin
        bus.opcode = 6'b000000;
        bus.mem_ready = 1'b1;

        step(1'b1, 6'b000000, 1'b1, "rst_outputs0", 24'd0);
        step(1'b1, 6'b000000, 1'b1, "rst_outputs1", 24'd0);
        check_eq("rst_count", 64'(bus.instr_count), 64'd0);

        // R-type: 4 cycles, retires on the 4th
        step(1'b0, 6'b000000, 1'b1, "r_fetch", v_fetch(1'b1));
        step(1'b0, 6'b000000, 1'b1, "r_decode", v_decode());
        step(1'b0, 6'b000000, 1'b1, "r_exec", v_alu(2'b01, 3'b000, 3'b010));
        step(1'b0, 6'b000000, 1'b1, "r_wb", v_wb(1'b0, 1'b1));

        // sw abandoned by a 3-cycle reset while stalled in MEM_WRITE
        step(1'b0, 6'b101011, 1'b1, "sw_fetch", v_fetch(1'b1));
        check_eq("r_count", 64'(bus.instr_count), 64'd1);
        step(1'b0, 6'b101011, 1'b1, "sw_decode", v_decode());
        step(1'b0, 6'b101011, 1'b1, "sw_addr", v_alu(2'b01, 3'b010, 3'b000));
        step(1'b0, 6'b101011, 1'b0, "sw_write_stall", v_memwr(2'b00, 1'b0));
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 6'b101011, 1'b0, "sw_rst_hold", 24'd0);
        end

        // lw with two stall cycles in MEM_READ; MEM_WB on cycle 7
        step(1'b0, 6'b100011, 1'b1, "post_rst_fetch", v_fetch(1'b1));
        check_eq("post_rst_count", 64'(bus.instr_count), 64'd0);
        step(1'b0, 6'b100011, 1'b1, "lw_decode", v_decode());
        step(1'b0, 6'b100011, 1'b1, "lw_addr", v_alu(2'b01, 3'b010, 3'b000));
        step(1'b0, 6'b100011, 1'b0, "lw_read_stall0", v_memrd(2'b00));
        step(1'b0, 6'b100011, 1'b0, "lw_read_stall1", v_memrd(2'b00));
        step(1'b0, 6'b100011, 1'b1, "lw_read_done", v_memrd(2'b00));
        step(1'b0, 6'b100011, 1'b1, "lw_wb", v_wb(1'b1, 1'b0));

        // bne: back in FETCH on cycle 4
        step(1'b0, 6'b000101, 1'b1, "bne_fetch", v_fetch(1'b1));
        check_eq("lw_count", 64'(bus.instr_count), 64'd1);
        step(1'b0, 6'b000101, 1'b1, "bne_decode", v_decode());
        step(1'b0, 6'b000101, 1'b1, "bne_branch", v_branch(1'b1));

        // I-type sequence: andi, ori, slti, lui
        run_imm(6'b001100, "andi", 2'b01, 3'b100, 3'b100);
        check_eq("bne_andi_count", 64'(bus.instr_count), 64'd2);
        run_imm(6'b001101, "ori", 2'b01, 3'b100, 3'b101);
        run_imm(6'b001010, "slti", 2'b01, 3'b010, 3'b110);
        run_imm(6'b001111, "lui", 2'b10, 3'b101, 3'b000);

        // Illegal opcode: single pulse, not counted
        step(1'b0, 6'b111111, 1'b1, "ill_fetch", v_fetch(1'b1));
        check_eq("imm_count", 64'(bus.instr_count), 64'd6);
        step(1'b0, 6'b111111, 1'b1, "ill_decode", v_decode());
        step(1'b0, 6'b111111, 1'b1, "ill_pulse",
             mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0,
                2'b00, 2'b00, 3'b000, 3'b000, 1'b1, 1'b0));

        // sb with a fetch stall, byte-size completing store
        step(1'b0, 6'b101000, 1'b0, "sb_fetch_stall", v_fetch(1'b0));
        check_eq("ill_count", 64'(bus.instr_count), 64'd6);
        step(1'b0, 6'b101000, 1'b1, "sb_fetch", v_fetch(1'b1));
        step(1'b0, 6'b101000, 1'b1, "sb_decode", v_decode());
        step(1'b0, 6'b101000, 1'b1, "sb_addr", v_alu(2'b01, 3'b010, 3'b000));
        step(1'b0, 6'b101000, 1'b1, "sb_write", v_memwr(2'b10, 1'b1));

        // j then beq
        step(1'b0, 6'b000010, 1'b1, "j_fetch", v_fetch(1'b1));
        check_eq("sb_count", 64'(bus.instr_count), 64'd7);
        step(1'b0, 6'b000010, 1'b1, "j_decode", v_decode());
        step(1'b0, 6'b000010, 1'b1, "j_jump",
             mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0,
                2'b10, 2'b00, 3'b000, 3'b000, 1'b0, 1'b1));
        step(1'b0, 6'b000100, 1'b1, "beq_fetch", v_fetch(1'b1));
        step(1'b0, 6'b000100, 1'b1, "beq_decode", v_decode());
        step(1'b0, 6'b000100, 1'b1, "beq_branch", v_branch(1'b0));
        step(1'b0, 6'b100101, 1'b0, "final_fetch", v_fetch(1'b0));
        check_eq("final_count", 64'(bus.instr_count), 64'd9);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
- Main control state machine of the multi-cycle MIPS datapath; sits directly upstream of the ALU control unit.
- Sequences each instruction through fetch/decode/execute/memory/writeback.
- Drives the 3-bit ALUOp consumed by the ALU control unit, plus all datapath mux selects and write strobes.
- Stalls on a memory-ready handshake and counts retired instructions.

Parameters:
CNT_W, 32, width of the retired-instruction counter

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous, active-high reset
opcode  input  6  IR[31:26]; valid from DECODE onward (IR written at end of FETCH)
mem_ready  input  1  memory completes the current read/write this cycle
PCWrite  output  1  unconditional PC write
PCWriteCondEq  output  1  PC write if ALU zero (beq)
PCWriteCondNe  output  1  PC write if ALU not zero (bne)
IorD  output  1  0 = PC addresses memory, 1 = ALUOut
MemRead  output  1  memory read request
MemWrite  output  1  memory write request
MemSize  output  2  00 word, 01 half, 10 byte
IRWrite  output  1  load instruction register
MemtoReg  output  1  1 = writeback from MDR
RegDst  output  1  1 = rd, 0 = rt
RegWrite  output  1  register file write
PCSource  output  2  00 ALU result, 01 ALUOut, 10 jump target
ALUSrcA  output  2  00 PC, 01 reg A, 10 constant zero
ALUSrcB  output  3  000 reg B, 001 const 4, 010 sign-ext imm, 011 sign-ext imm<<2, 100 zero-ext imm, 101 imm<<16
ALUOp  output  3  000 add, 001 sub, 010 R-type (use func), 100 and, 101 or, 110 slt
illegal_op  output  1  one-cycle pulse on unsupported opcode
retired  output  1  one-cycle pulse when an instruction completes
instr_count  output  CNT_W  count of retired instructions

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high.
- rst high at a clock edge: state <= FETCH, instr_count <= 0.
- While rst is high, every strobe (PCWrite*, Mem*, IRWrite, RegWrite, retired, illegal_op) is forced to 0. Selects read 0.
- Reset mid-instruction abandons the instruction; no write strobe is issued.
- Outputs: Moore decode of state. Only IRWrite/PCWrite in FETCH are additionally gated by mem_ready. Unlisted outputs are 0 in each state.
- 4-bit state encoding: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_READ=3, MEM_WB=4, MEM_WRITE=5, R_EXEC=6, R_WB=7, BRANCH=8, JUMP=9, I_EXEC=10, I_WB=11, ILLEGAL=12. Undefined codes go to FETCH.
- FETCH:
  - MemRead=1, IorD=0, ALUSrcA=00, ALUSrcB=001, ALUOp=000, PCSource=00.
  - IRWrite = PCWrite = mem_ready.
  - Stays in FETCH while mem_ready=0; otherwise goes to DECODE.
- DECODE:
  - ALUSrcA=00, ALUSrcB=011, ALUOp=000 (branch target precompute).
  - Dispatch on opcode:
    - 000000 → R_EXEC
    - 000010 → JUMP
    - 000100/000101 → BRANCH
    - 100011 lw, 100100 lbu, 100101 lhu, 101011 sw, 101001 sh, 101000 sb → MEM_ADDR
    - 001000 addi, 001001 addiu, 001010 slti, 001011 sltiu, 001100 andi, 001101 ori, 001111 lui → I_EXEC
    - any other opcode → ILLEGAL
- MEM_ADDR: ALUSrcA=01, ALUSrcB=010, ALUOp=000. Loads → MEM_READ; stores → MEM_WRITE.
- MEM_READ:
  - IorD=1, MemRead=1.
  - MemSize: lw/sw 00, lhu/sh 01, lbu/sb 10. The same mapping applies in MEM_WRITE.
  - Holds until mem_ready, then → MEM_WB.
- MEM_WB: RegDst=0, MemtoReg=1, RegWrite=1, retired=1 → FETCH.
- MEM_WRITE: IorD=1, MemWrite=1, held until mem_ready. On the mem_ready cycle retired=1 → FETCH.
- R_EXEC: ALUSrcA=01, ALUSrcB=000, ALUOp=010 → R_WB.
- R_WB: RegDst=1, RegWrite=1, retired=1 → FETCH.
- BRANCH:
  - ALUSrcA=01, ALUSrcB=000, ALUOp=001, PCSource=01.
  - PCWriteCondEq=1 for beq; PCWriteCondNe=1 for bne.
  - retired=1 → FETCH.
- JUMP: PCSource=10, PCWrite=1, retired=1 → FETCH.
- I_EXEC: ALUSrcA=01 and, per opcode:
  - addi/addiu: ALUSrcB 010, ALUOp 000
  - slti/sltiu: ALUSrcB 010, ALUOp 110
  - andi: ALUSrcB 100, ALUOp 100
  - ori: ALUSrcB 100, ALUOp 101
  - lui: ALUSrcA 10, ALUSrcB 101, ALUOp 000
  - next state I_WB
- I_WB: RegDst=0, MemtoReg=0, RegWrite=1, retired=1 → FETCH.
- ILLEGAL: illegal_op=1, no writes, not counted → FETCH. The PC has already advanced by 4.
- Counter: instr_count increments on each cycle retired=1. Wraps modulo 2^CNT_W with no saturation.
- Cycle counts with mem_ready always 1:
  - R-type, addi, sw: 4
  - lw: 5
  - beq, j: 3
- Each mem_ready=0 cycle in FETCH, MEM_READ or MEM_WRITE adds one cycle.

Decomposition:
- Shared package mips_ctrl_pkg:
  - opcode localparams
  - ALUOp encodings (must match the ALU control unit: 000/001/010/100/101/110)
  - ALUSrcA/ALUSrcB/PCSource/MemSize encodings
  - state encodings
- One natural sub-module, mc_opcode_decoder:
  - combinational opcode → {class, MemSize, I-type ALUOp/ALUSrcB}
  - keeps the FSM to state register plus output decode

Test Plan:
- rst=1 held for 3 cycles mid-MEM_WRITE → MemWrite=0 during reset; state=FETCH and instr_count=0 on release.
- opcode=000000, mem_ready=1 → FETCH, DECODE, R_EXEC (ALUOp=010), R_WB (RegWrite=1, RegDst=1); retired pulses at cycle 4; instr_count=1.
- lw (100011) with mem_ready low for 2 cycles in MEM_READ → MemRead/IorD=1 held; MEM_WB reached at cycle 7; MemtoReg=1, RegWrite=1.
- bne (000101) → BRANCH with ALUOp=001, PCWriteCondNe=1, PCWriteCondEq=0, PCSource=01; back in FETCH at cycle 4.
- andi/ori/slti/lui in sequence → I_EXEC ALUOp/ALUSrcB = 100/100, 101/100, 110/010, 000/101 (lui also ALUSrcA=10); instr_count advances by 4.
- opcode=111111 → ILLEGAL: illegal_op pulses once, no RegWrite/MemWrite, instr_count unchanged; FETCH next.
